// File: rtl/scan_sequencer_138.sv
// Scan driver for a 3-to-8 decoder: a blank gap then a dwell per slot, with registered address, enables and data.
// Optional SCAN_DIGIT_MASK_EN adds digit_mask to keep selected slots dark while preserving frame timing.
module scan_sequencer_138 #(
    parameter int NUM_DIGITS   = 8,
    parameter int DATA_W       = 8,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits_in,
`ifdef SCAN_DIGIT_MASK_EN
    input  logic [NUM_DIGITS-1:0]        digit_mask,
`endif
    output logic                         A0,
    output logic                         A1,
    output logic                         A2,
    output logic                         G1,
    output logic                         G2,
    output logic                         G3,
    output logic [DATA_W-1:0]            seg_out,
    output logic                         frame_start,
    output logic                         busy,
    output logic [1:0]                   state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       G_ON       = 3'b100;
    localparam logic [2:0]       G_OFF      = 3'b011;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2:0]          g_q, g_d;
    logic [DATA_W-1:0]   seg_q, seg_d;
    logic                fs_q, fs_d;
    logic                load_slot;
    logic                slot_off;
    logic [DATA_W-1:0]   slot_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            g_q     <= G_OFF;
            seg_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            g_q     <= g_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        g_d       = g_q;
        seg_d     = seg_q;
        fs_d      = 1'b0;
        load_slot = 1'b0;
        slot_off  = 1'b0;
        slot_data = '0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    idx_d = '0;
                    fs_d  = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        state_d   = ACTIVE;
                        cnt_d     = DWELL_LOAD;
                        load_slot = 1'b1;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                        g_d     = G_OFF;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d   = ACTIVE;
                    cnt_d     = DWELL_LOAD;
                    load_slot = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    fs_d  = (idx_d == '0);
                    if (BLANK_CYCLES == 0) begin
                        cnt_d     = DWELL_LOAD;
                        load_slot = 1'b1;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                        g_d     = G_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The slot latch always uses the index the new ACTIVE phase will show.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) slot_data = digits_in[i*DATA_W +: DATA_W];
        end
`ifdef SCAN_DIGIT_MASK_EN
        slot_off = digit_mask[idx_d];
`endif
        if (load_slot) begin
            seg_d = slot_off ? '0 : slot_data;
            g_d   = slot_off ? G_OFF : G_ON;
        end

        // Dropping en abandons the partial slot; a later en restarts at slot 0.
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            g_d     = G_OFF;
            seg_d   = '0;
            fs_d    = 1'b0;
        end
    end

    assign {A2, A1, A0} = 3'(idx_q);
    assign {G1, G2, G3} = g_q;
    assign seg_out      = seg_q;
    assign frame_start  = fs_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_scan_sequencer_138.sv
// Directed bench for scan_sequencer_138: a blank=2 instance and a back-to-back (blank=0) instance share stimulus.
// Build with SCAN_DIGIT_MASK_EN to add the masked-slot sequence.
module tb_scan_sequencer_138;

    localparam int ND    = 3;
    localparam int DW    = 8;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [ND*DW-1:0] digits;
`ifdef SCAN_DIGIT_MASK_EN
    logic [ND-1:0] mask;
`endif

    logic a0, a1, a2, g1, g2, g3, fs, busy;
    logic [DW-1:0] seg;
    logic [1:0] st;
    logic z_a0, z_a1, z_a2, z_g1, z_g2, z_g3, z_fs, z_busy;
    logic [DW-1:0] z_seg;
    logic [1:0] z_st;

    logic [7:0] exp_dig [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_sequencer_138 #(
        .NUM_DIGITS(ND), .DATA_W(DW), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits),
`ifdef SCAN_DIGIT_MASK_EN
        .digit_mask(mask),
`endif
        .A0(a0), .A1(a1), .A2(a2), .G1(g1), .G2(g2), .G3(g3),
        .seg_out(seg), .frame_start(fs), .busy(busy), .state_dbg_o(st)
    );

    scan_sequencer_138 #(
        .NUM_DIGITS(ND), .DATA_W(DW), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits),
`ifdef SCAN_DIGIT_MASK_EN
        .digit_mask(mask),
`endif
        .A0(z_a0), .A1(z_a1), .A2(z_a2), .G1(z_g1), .G2(z_g2), .G3(z_g3),
        .seg_out(z_seg), .frame_start(z_fs), .busy(z_busy), .state_dbg_o(z_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_g"},    32'({g1, g2, g3}), 32'(3'b011));
        chk({tag, "_a"},    32'({a2, a1, a0}), 32'(0));
        chk({tag, "_seg"},  32'(seg), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_fs"},   32'(fs), 32'(0));
        chk({tag, "_st"},   32'(st), 32'(0));
        chk({tag, "_z_g"},  32'({z_g1, z_g2, z_g3}), 32'(3'b011));
        chk({tag, "_z_a"},  32'({z_a2, z_a1, z_a0}), 32'(0));
        chk({tag, "_z_seg"}, 32'(z_seg), 32'(0));
        chk({tag, "_z_busy"}, 32'(z_busy), 32'(0));
    endtask

    // k = cycle count since scanning began; 6-cycle slots: 2 blank, 4 active.
    task automatic chk_main(input int k, input logic [2:0] m);
        int p, s, c;
        logic [2:0] eg;
        logic [7:0] es;
        p  = (k - 1) % 18;
        s  = p / 6;
        c  = p % 6;
        eg = (c < 2 || m[s]) ? 3'b011 : 3'b100;
        es = m[s] ? 8'h00 : exp_dig[s];
        chk($sformatf("main_a_k%0d", k),    32'({a2, a1, a0}), 32'(s));
        chk($sformatf("main_g_k%0d", k),    32'({g1, g2, g3}), 32'(eg));
        chk($sformatf("main_fs_k%0d", k),   32'(fs), 32'(p == 0));
        chk($sformatf("main_busy_k%0d", k), 32'(busy), 32'(1));
        chk($sformatf("main_st_k%0d", k),   32'(st), (c < 2) ? 32'(1) : 32'(2));
        if (c >= 2) chk($sformatf("main_seg_k%0d", k), 32'(seg), 32'(es));
    endtask

    // Back-to-back instance: 4-cycle slots, always enabled.
    task automatic chk_zero(input int k);
        int p, s;
        p = (k - 1) % 12;
        s = p / 4;
        chk($sformatf("zero_a_k%0d", k),   32'({z_a2, z_a1, z_a0}), 32'(s));
        chk($sformatf("zero_g_k%0d", k),   32'({z_g1, z_g2, z_g3}), 32'(3'b100));
        chk($sformatf("zero_fs_k%0d", k),  32'(z_fs), 32'(p == 0));
        chk($sformatf("zero_seg_k%0d", k), 32'(z_seg), 32'(exp_dig[s]));
        chk($sformatf("zero_st_k%0d", k),  32'(z_st), 32'(2));
    endtask

    initial begin
        exp_dig[0] = 8'hA1;
        exp_dig[1] = 8'hB2;
        exp_dig[2] = 8'hC3;
        rst    = 1'b1;
        en     = 1'b1;
        digits = {8'hC3, 8'hB2, 8'hA1};
`ifdef SCAN_DIGIT_MASK_EN
        mask   = 3'b000;
`endif

        // Reset held two cycles with en high.
        repeat (2) @(negedge clk);
        chk_idle("reset");

        // Two full frames plus part of a third, through the 2nd active cycle of slot 1.
        rst = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            chk_main(k, 3'b000);
            chk_zero(k);
            // Slot 0 is already latched; the new value must wait for the next latch.
            if (k == 39) digits[7:0] = 8'h5A;
        end

        // Drop en mid-slot: idle on the next edge, and stays there.
        en = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        @(negedge clk);
        chk_idle("abort_hold");

        // Restart at slot 0 with frame_start, picking up the changed slot 0 data.
        en = 1'b1;
        @(negedge clk);
        chk("restart_a",    32'({a2, a1, a0}), 32'(0));
        chk("restart_g",    32'({g1, g2, g3}), 32'(3'b011));
        chk("restart_fs",   32'(fs), 32'(1));
        chk("restart_busy", 32'(busy), 32'(1));
        chk("restart_z_g",  32'({z_g1, z_g2, z_g3}), 32'(3'b100));
        chk("restart_z_seg", 32'(z_seg), 32'(8'h5A));
        chk("restart_z_fs", 32'(z_fs), 32'(1));
        @(negedge clk);
        chk("restart_fs_drop", 32'(fs), 32'(0));
        chk("restart_g_blank2", 32'({g1, g2, g3}), 32'(3'b011));
        @(negedge clk);
        chk("restart_g_active", 32'({g1, g2, g3}), 32'(3'b100));
        chk("restart_seg",      32'(seg), 32'(8'h5A));

        // Reset wins mid-slot even with en high.
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");

`ifdef SCAN_DIGIT_MASK_EN
        // Slot 1 masked: dark for its whole active phase, frame timing unchanged.
        digits = {8'hC3, 8'hB2, 8'hA1};
        mask   = 3'b010;
        rst    = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            chk_main(k, 3'b010);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
